// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the fully connected layer.
package fc_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FINISH = 2'd1,
    OUT    = 2'd2
  } fc_state_e;

  // Accumulator wide enough for in_size full-precision products plus sign.
  function automatic int unsigned acc_width(input int unsigned word_size,
                                            input int unsigned in_size);
    return 2 * word_size + $clog2(in_size) + 1;
  endfunction

endpackage

// File: rtl/fc_mac.sv
// One neuron lane: signed MAC, then bias add, fixed-point rescale and narrow.
// Narrowing saturates when FC_SATURATE_EN is defined, otherwise wraps.
module fc_mac
  import fc_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned ACC_W     = 35
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        acc_en,
  input  logic                        clear,
  input  logic                        load_y,
  input  logic signed [WORD_SIZE-1:0] x,
  input  logic signed [WORD_SIZE-1:0] w,
  input  logic signed [WORD_SIZE-1:0] b,
  output logic signed [WORD_SIZE-1:0] y
);

  localparam int unsigned PROD_W = 2 * WORD_SIZE;
  localparam int unsigned SUM_W  = ACC_W + 1;

  logic signed [ACC_W-1:0]     acc;
  logic signed [PROD_W-1:0]    prod_c;
  logic signed [SUM_W-1:0]     sum_c;
  logic signed [SUM_W-1:0]     shr_c;
  logic signed [WORD_SIZE-1:0] res_c;

  assign prod_c = PROD_W'(x) * PROD_W'(w);

  // Bias is aligned to the product scale before the single floor shift.
  always_comb begin
    sum_c = SUM_W'(acc) + (SUM_W'(b) <<< FRAC_BITS);
    shr_c = sum_c >>> FRAC_BITS;
`ifdef FC_SATURATE_EN
    if ((shr_c[SUM_W-1:WORD_SIZE-1] == '0) || (shr_c[SUM_W-1:WORD_SIZE-1] == '1)) begin
      res_c = WORD_SIZE'(shr_c);
    end else if (shr_c[SUM_W-1]) begin
      res_c = {1'b1, {(WORD_SIZE-1){1'b0}}};
    end else begin
      res_c = {1'b0, {(WORD_SIZE-1){1'b1}}};
    end
`else
    res_c = WORD_SIZE'(shr_c);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
      y   <= '0;
    end else begin
      if (clear) begin
        acc <= '0;
      end else if (acc_en) begin
        acc <= acc + ACC_W'(prod_c);
      end
      if (load_y) begin
        y <= res_c;
      end
    end
  end

endmodule

// File: rtl/fc_layer.sv
// Fully connected layer: streams IN_SIZE inputs through LAYER_SIZE MAC lanes.
// Define FC_SATURATE_EN to clamp outputs instead of wrapping them.
module fc_layer
  import fc_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned IN_SIZE    = 84,
  parameter int unsigned LAYER_SIZE = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic signed [WORD_SIZE-1:0]     in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [$clog2(IN_SIZE)-1:0]      w_addr,
  input  logic [LAYER_SIZE*WORD_SIZE-1:0] w_data,
  input  logic [LAYER_SIZE*WORD_SIZE-1:0] b_data,
  output logic [LAYER_SIZE*WORD_SIZE-1:0] Y,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int unsigned IDX_W = $clog2(IN_SIZE);
  localparam int unsigned ACC_W = acc_width(WORD_SIZE, IN_SIZE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN_SIZE - 1);

  fc_state_e        state;
  logic [IDX_W-1:0] idx;
  logic             xfer;
  logic             load_y;
  logic             clear;

  assign xfer   = (state == ACCUM) && in_valid && in_ready;
  assign load_y = (state == FINISH);
  assign clear  = (state == OUT) && out_valid && out_ready;
  assign w_addr = idx;

  // out_valid trails entry into OUT by one cycle so Y is settled when it rises.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ACCUM;
      idx       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          in_ready <= 1'b1;
          if (xfer) begin
            if (idx == IDX_LAST) begin
              idx      <= '0;
              state    <= FINISH;
              in_ready <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        FINISH: begin
          state <= OUT;
        end
        OUT: begin
          if (out_valid && out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= ACCUM;
          idx       <= '0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  for (genvar n = 0; n < LAYER_SIZE; n++) begin : g_lane
    fc_mac #(
      .WORD_SIZE(WORD_SIZE),
      .FRAC_BITS(FRAC_BITS),
      .ACC_W    (ACC_W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .acc_en(xfer),
      .clear (clear),
      .load_y(load_y),
      .x     (in_data),
      .w     (w_data[n*WORD_SIZE +: WORD_SIZE]),
      .b     (b_data[n*WORD_SIZE +: WORD_SIZE]),
      .y     (Y[n*WORD_SIZE +: WORD_SIZE])
    );
  end

endmodule

// File: tb/tb_fc_layer.sv
// Directed bench for fc_layer with a 4-element, 10-neuron configuration.
module tb_fc_layer;

  localparam int W = 16;
  localparam int N = 4;
  localparam int L = 10;

  logic                clk;
  logic                reset;
  logic signed [W-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          w_addr;
  logic [L*W-1:0]      w_data;
  logic [L*W-1:0]      b_data;
  logic [L*W-1:0]      Y;
  logic                out_valid;
  logic                out_ready;

  logic signed [W-1:0] wtab [N][L];
  logic signed [W-1:0] bias [L];
  logic signed [W-1:0] xin  [N];
  logic [W-1:0]        lane_y;

  int n_pass  = 0;
  int n_total = 0;

  fc_layer #(
    .WORD_SIZE (16),
    .FRAC_BITS (8),
    .IN_SIZE   (N),
    .LAYER_SIZE(L)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .b_data   (b_data),
    .Y        (Y),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational weight ROM and static bias bank.
  always_comb begin
    w_data = '0;
    b_data = '0;
    for (int n = 0; n < L; n++) begin
      w_data[n*W +: W] = wtab[w_addr][n];
      b_data[n*W +: W] = bias[n];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] golden(input int n);
    longint acc;
    acc = 0;
    for (int k = 0; k < N; k++) acc += longint'(xin[k]) * longint'(wtab[k][n]);
    acc += longint'(bias[n]) <<< 8;
    acc = acc >>> 8;
`ifdef FC_SATURATE_EN
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`endif
    return W'(acc);
  endfunction

  task automatic set_all(input logic [W-1:0] x, input logic [W-1:0] wv, input logic [W-1:0] bv);
    for (int k = 0; k < N; k++) begin
      xin[k] = x;
      for (int n = 0; n < L; n++) wtab[k][n] = wv;
    end
    for (int n = 0; n < L; n++) bias[n] = bv;
  endtask

  // Offer one element after `gap` idle cycles; returns 1ns after the accepting edge.
  task automatic push(input logic [W-1:0] d, input int gap);
    int guard;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_data  = d;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (guard == 50) begin
      n_total++;
      $display("FAIL push_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int guard;
    guard = 0;
    while (!out_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL out_timeout: out_valid=%b required 1", out_valid);
    else n_pass++;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    set_all(16'h0100, 16'h0100, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid);
    else n_pass++;
    n_total++;
    if (Y !== '0) $display("FAIL reset_y: got %h required 0", Y);
    else n_pass++;
    n_total++;
    if (w_addr !== 2'd0) $display("FAIL reset_w_addr: got %0d required 0", w_addr);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_ones();
    set_all(16'h0100, 16'h0100, 16'h0000);
    for (int k = 0; k < N; k++) push(16'h0100, 0);
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL lat_t0: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL lat_t1: out_valid=%b required 0", out_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL lat_t2: out_valid=%b required 1", out_valid);
    else n_pass++;
    for (int n = 0; n < L; n++) begin
      lane_y = Y[n*W +: W];
      n_total++;
      if (lane_y !== 16'h0400) $display("FAIL ones_lane%0d: got %h required 0400", n, lane_y);
      else n_pass++;
    end
    drain();
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL ones_drain: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_negative();
    set_all(16'h0100, 16'hFF80, 16'h0040);
    for (int k = 0; k < N; k++) push(16'h0100, 0);
    wait_out();
    for (int n = 0; n < L; n++) begin
      lane_y = Y[n*W +: W];
      n_total++;
      if (lane_y !== 16'hFE40) $display("FAIL neg_lane%0d: got %h required FE40", n, lane_y);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_v;
`ifdef FC_SATURATE_EN
    exp_v = 16'h7FFF;
`else
    exp_v = 16'hFC00;
`endif
    set_all(16'h7FFF, 16'h7FFF, 16'h0000);
    for (int k = 0; k < N; k++) push(16'h7FFF, 0);
    wait_out();
    for (int n = 0; n < L; n += 3) begin
      lane_y = Y[n*W +: W];
      n_total++;
      if (lane_y !== exp_v) $display("FAIL ovf_lane%0d: got %h required %h", n, lane_y, exp_v);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_out_stall();
    logic [L*W-1:0] held;
    set_all(16'h0100, 16'h0100, 16'h0000);
    for (int k = 0; k < N; k++) push(16'h0100, 0);
    wait_out();
    held = Y;
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      in_data  = 16'h7777;
      @(posedge clk); #1;
      n_total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Y !== held || w_addr !== 2'd0)
        $display("FAIL stall_c%0d: out_valid=%b in_ready=%b w_addr=%0d y_held=%b required 1 0 0 1",
                 c, out_valid, in_ready, w_addr, (Y === held));
      else n_pass++;
    end
    in_valid = 1'b0;
    drain();
    for (int k = 0; k < N; k++) push(16'h0100, 1);
    wait_out();
    lane_y = Y[7*W +: W];
    n_total++;
    if (lane_y !== 16'h0400) $display("FAIL stall_next: got %h required 0400", lane_y);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    set_all(16'h0100, 16'h0100, 16'h0000);
    push(16'h0100, 0);
    push(16'h0100, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (w_addr !== 2'd0 || in_ready !== 1'b0)
      $display("FAIL midrst_state: w_addr=%0d in_ready=%b required 0 0", w_addr, in_ready);
    else n_pass++;
    reset = 1'b1;
    for (int k = 0; k < N; k++) push(16'h0100, 0);
    wait_out();
    for (int n = 0; n < L; n += 4) begin
      lane_y = Y[n*W +: W];
      n_total++;
      if (lane_y !== 16'h0400) $display("FAIL midrst_lane%0d: got %h required 0400", n, lane_y);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_gaps();
    logic [W-1:0] exp_v;
    xin[0] = 16'h0180; xin[1] = 16'hFF00; xin[2] = 16'h0040; xin[3] = 16'h0220;
    for (int k = 0; k < N; k++)
      for (int n = 0; n < L; n++) wtab[k][n] = W'((n + 1) * 32 - k * 48);
    for (int n = 0; n < L; n++) bias[n] = W'(n * 16 - 48);
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_total++;
      if (w_addr !== 2'(k)) $display("FAIL gap_waddr%0d: got %0d required %0d", k, w_addr, k);
      else n_pass++;
      push(xin[k], 0);
    end
    wait_out();
    for (int n = 0; n < L; n++) begin
      exp_v  = golden(n);
      lane_y = Y[n*W +: W];
      n_total++;
      if (lane_y !== exp_v) $display("FAIL gap_lane%0d: got %h required %h", n, lane_y, exp_v);
      else n_pass++;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_ones();
    test_negative();
    test_overflow();
    test_out_stall();
    test_reset_mid();
    test_gaps();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
